// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/[parity]/stop framing with a one-clock Data_Rdy strobe.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
//
// Output handshake: Data_Rdy is a valid-only strobe with no ready. It is high for exactly
// one clock, and Rx_Data is stable from that clock until the next strobe.
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int BAUD_DIVISOR = 27,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx,
  input  logic                 BIST_Mode,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Framing_Err,
  output logic                 Parity_Err,
  output logic                 Rx_Busy,
  output logic [2:0]           state_dbg
);

  localparam int BW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIVISOR - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   rx_prev;
  logic [BW-1:0]          baud_cnt;
  logic [TW-1:0]          tick_cnt;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;

  logic tick;
  logic sample_pt;
  logic start_edge;

  assign tick       = (state != IDLE) && (baud_cnt == BAUD_LAST);
  // START samples half a bit in so every later sample lands mid-bit.
  assign sample_pt  = tick && (tick_cnt == ((state == START) ? HALF_LAST : FULL_LAST));
  assign start_edge = rx_prev && !rx_s;

  assign Rx_Busy   = (state != IDLE);
  assign state_dbg = state;

`ifdef UART_RX_PARITY_EN
  logic par_expect;
  logic par_mis;
  logic par_err_q;

  assign par_expect = (^shift_reg) ^ (PARITY_ODD != 0);
  assign Parity_Err = par_err_q;
`else
  assign Parity_Err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      baud_cnt    <= '0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      Rx_Data     <= '0;
      Data_Rdy    <= 1'b0;
      Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_meta  <= Rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      Data_Rdy <= 1'b0;

      // Counters idle at zero, so entering START always begins a fresh bit period.
      if (BIST_Mode || state == IDLE) begin
        baud_cnt <= '0;
        tick_cnt <= '0;
      end else begin
        baud_cnt <= (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + 1'b1;
        if (sample_pt) begin
          tick_cnt <= '0;
        end else if (tick) begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end

      if (BIST_Mode) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) state <= START;
          end
          START: begin
            if (sample_pt) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
          end
          DATA: begin
            if (sample_pt) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (sample_pt) begin
              par_mis <= (rx_s != par_expect);
              state   <= STOP;
            end
          end
`endif
          STOP: begin
            // Returning to IDLE mid-stop-bit leaves time to catch a back-to-back start edge.
            if (sample_pt) begin
              if (rx_s) begin
                Rx_Data     <= shift_reg;
                Data_Rdy    <= 1'b1;
                Framing_Err <= 1'b0;
              end else begin
                Framing_Err <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              par_err_q <= par_mis;
`endif
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 64 clocks per bit; expected characters go through exp_q.
module tb_uart_rx;

  localparam int BD         = 4;
  localparam int OS         = 16;
  localparam int BIT_CLKS   = BD * OS;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       bist_mode;
  logic [7:0] rx_data;
  logic       data_rdy;
  logic       framing_err;
  logic       parity_err;
  logic       rx_busy;
  logic [2:0] state_dbg;

  uart_rx #(
    .DATA_BITS   (8),
    .OVERSAMPLE  (OS),
    .BAUD_DIVISOR(BD),
    .PARITY_ODD  (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rx         (rx),
    .BIST_Mode  (bist_mode),
    .Rx_Data    (rx_data),
    .Data_Rdy   (data_rdy),
    .Framing_Err(framing_err),
    .Parity_Err (parity_err),
    .Rx_Busy    (rx_busy),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle count
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [7:0] exp_q[$];
  int checks;
  int errors;
  int rdy_count;
  int last_rdy_cyc;
  int prev_rdy_cyc;
  logic rdy_q;
  logic rdy_wide;

  initial begin
    checks = 0; errors = 0; rdy_count = 0;
    last_rdy_cyc = 0; prev_rdy_cyc = 0;
    rdy_q = 1'b0; rdy_wide = 1'b0;
  end

  always @(negedge clk) begin
    if (data_rdy && rdy_q) rdy_wide = 1'b1;
    rdy_q = data_rdy;
    if (data_rdy) begin
      rdy_count++;
      prev_rdy_cyc = last_rdy_cyc;
      last_rdy_cyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rdy_spurious: observed strobe with data %0h, required no strobe", rx_data);
      end
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (rx_data === e) else begin
          errors++;
          $error("FAIL rdy_data: observed %0h required %0h", rx_data, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, BIT_CLKS);
`else
    if (par) rx = 1'b1;
`endif
    drive_bit(stop, BIT_CLKS);
    rx = 1'b1;
  endtask

  int base;

  initial begin
    rst = 1'b1; rx = 1'b1; bist_mode = 1'b0;
    idle(5);
    rst = 1'b0;
    idle(2);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_rdy", data_rdy, 1'b0);
    chk("reset_ferr", framing_err, 1'b0);
    chk("reset_perr", parity_err, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);

    // False start: 20 clocks low is gone before the half-bit sample.
    base = rdy_count;
    drive_bit(1'b0, 10);
    chk("glitch_busy_high", rx_busy, 1'b1);
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 100);
    chk("glitch_busy_low", rx_busy, 1'b0);
    chk("glitch_no_rdy", rdy_count - base, 0);
    chk("glitch_data", rx_data, 8'h00);

    // Good 0xA5
    base = rdy_count;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    chk("a5_rdy_count", rdy_count - base, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr", framing_err, 1'b0);
    chk("a5_busy", rx_busy, 1'b0);

    // 0x3C with bad stop bit, then a good 0x3C
    base = rdy_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(30);
    chk("ferr_set", framing_err, 1'b1);
    chk("ferr_no_rdy", rdy_count - base, 0);
    chk("ferr_data_hold", rx_data, 8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(20);
    chk("ferr_recover_rdy", rdy_count - base, 1);
    chk("ferr_recover_data", rx_data, 8'h3C);
    chk("ferr_clear", framing_err, 1'b0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x01 needs parity bit 1.
    base = rdy_count;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(20);
    chk("par_bad_rdy", rdy_count - base, 1);
    chk("par_bad_data", rx_data, 8'h01);
    chk("par_bad_perr", parity_err, 1'b1);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(20);
    chk("par_good_rdy", rdy_count - base, 2);
    chk("par_good_perr", parity_err, 1'b0);
`endif

    // Back-to-back 0x00 then 0xFF, no gap (parity bit matches even parity)
    base = rdy_count;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(20);
    chk("b2b_rdy_count", rdy_count - base, 2);
    chk("b2b_spacing", last_rdy_cyc - prev_rdy_cyc, FRAME_CLKS);
    chk("b2b_data", rx_data, 8'hFF);
    chk("b2b_perr", parity_err, 1'b0);

    // Reset during data bit 4
    base = rdy_count;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(i[0], BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS / 2);
    chk("rst_pre_busy", rx_busy, 1'b1);
    rst = 1'b1;
    rx = 1'b1;
    idle(2);
    chk("rst_mid_busy", rx_busy, 1'b0);
    chk("rst_mid_data", rx_data, 8'h00);
    rst = 1'b0;
    idle(FRAME_CLKS);
    chk("rst_no_rdy", rdy_count - base, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", framing_err, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);

    // BIST asserted mid-frame discards it
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS / 2);
    chk("bist_pre_busy", rx_busy, 1'b1);
    bist_mode = 1'b1;
    idle(2);
    chk("bist_busy", rx_busy, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(i[1], BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    idle(10);
    chk("bist_hold_busy", rx_busy, 1'b0);
    bist_mode = 1'b0;
    idle(BIT_CLKS);
    chk("bist_no_rdy", rdy_count - base, 0);
    chk("bist_data", rx_data, 8'h00);
    chk("bist_ferr", framing_err, 1'b0);

    // Normal reception after BIST
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(20);
    chk("post_rdy", rdy_count - base, 1);
    chk("post_data", rx_data, 8'h5A);
    chk("post_ferr", framing_err, 1'b0);

    // Final report
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rdy_single_cycle", rdy_wide, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver feeding the receive FIFO. It oversamples the asynchronous serial line, frames start/data/optional parity/stop bits, and presents each good character on `Rx_Data` with a one-clock `Data_Rdy` strobe that the FIFO consumes directly. It also reports framing and parity errors.

## Interface
- `DATA_BITS`, 8: character width; matches the FIFO `DATA_BITS`.
- `OVERSAMPLE`, 16: oversample ticks per bit period; must be even and ≥4.
- `BAUD_DIVISOR`, 27: clocks per oversample tick; ≥1.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Used only when parity is compiled in.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `Rx`  in  1  asynchronous serial line; idle level is 1.
- `BIST_Mode`  in  1  holds the receiver in IDLE and suppresses all strobes.
- `Rx_Data`  out  DATA_BITS  last good character, LSB received first.
- `Data_Rdy`  out  1  one-clock pulse when `Rx_Data` is updated.
- `Framing_Err`  out  1  the last frame's stop bit sampled 0.
- `Parity_Err`  out  1  the last frame's parity mismatched.
- `Rx_Busy`  out  1  high whenever the state is not IDLE.

## Operation
- `Rx` passes through a 2-flop synchronizer whose flops reset to 1. All logic uses the synchronized value `rx_s`.
- Tick generator:
  - Counter runs 0..BAUD_DIVISOR-1, issuing a tick when count == BAUD_DIVISOR-1.
  - It is held at 0 in IDLE and cleared on entry to START.
  - A separate tick counter spans 0..OVERSAMPLE-1.
- States: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** a falling edge of `rx_s` (previous 1, current 0) with `BIST_Mode`=0 moves to START.
- **START:** after OVERSAMPLE/2 ticks, sample `rx_s`.
  - 1: false start; return to IDLE with no output change.
  - 0: go to DATA, clear the bit counter.
- **DATA:** every OVERSAMPLE ticks, sample `rx_s` into a right-shifting register (LSB first).
  - After DATA_BITS samples, go to PARITY if it is compiled in, else STOP.
- **PARITY:** after OVERSAMPLE ticks, sample the parity bit and compare it with the XOR of the data, inverted when `PARITY_ODD`=1. Then go to STOP.
- **STOP:** after OVERSAMPLE ticks, sample the stop bit.
  - 1: load `Rx_Data` from the shift register, pulse `Data_Rdy`, clear `Framing_Err`, and load `Parity_Err` with the mismatch result.
  - 0: set `Framing_Err`, load `Parity_Err`, no `Data_Rdy`, `Rx_Data` unchanged.
  - Always return to IDLE.
- After a framing error (line held low), IDLE waits for `rx_s`=1 before accepting the next start edge. This falls out of the edge detect.
- `BIST_Mode`=1 in any state forces IDLE on the next clock; a partial frame is discarded, and error flags and `Rx_Data` hold.
- `Framing_Err` and `Parity_Err` hold until the next completed stop sample.

## Timing
- Reset values: `Rx_Data`=0, `Data_Rdy`=0, `Framing_Err`=0, `Parity_Err`=0, `Rx_Busy`=0, state IDLE, synchronizer=1, all counters 0.
- Reset asserted mid-frame aborts the frame immediately, with no strobe.
- Let T be the clock where the start edge is detected (2 clocks after the `Rx` pin falls). Let B = OVERSAMPLE·BAUD_DIVISOR.
  - Start sample: T + (OVERSAMPLE/2)·BAUD_DIVISOR.
  - Data bit k sample: start sample + (k+1)·B.
  - Stop sample: start sample + (DATA_BITS+1+P)·B, where P=1 with parity compiled in, else 0.
- `Data_Rdy` and the updated `Rx_Data`/flags are registered and visible the clock after the stop sample. `Data_Rdy` is high for exactly one clock.
- `Rx_Busy` rises the clock after T and falls with the return to IDLE.
- Back-to-back frames (a new start bit immediately after the stop bit) are received without loss. IDLE is re-entered mid-stop-bit, before the next falling edge.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, frames are start + DATA_BITS + parity + stop, and `Parity_Err` is live.
- Not defined: no PARITY state, frames are start + DATA_BITS + stop, and `Parity_Err` is tied to 0.

## Test plan
All scenarios use BAUD_DIVISOR=4 and OVERSAMPLE=16 (64 clocks per bit).
- Send 0xA5 with a good stop bit -> exactly one `Data_Rdy` pulse with `Rx_Data`=0xA5 and `Framing_Err`=0.
- Drive `Rx` low for 20 clocks, then high -> no `Data_Rdy`, `Rx_Busy` returns to 0, `Rx_Data` stays 0x00.
- Send 0x3C with stop bit 0 -> `Framing_Err`=1, no `Data_Rdy`. A following good 0x3C frame gives `Data_Rdy` with `Rx_Data`=0x3C and `Framing_Err`=0.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0, send 0x01 with parity bit 0 -> `Data_Rdy` pulses, `Rx_Data`=0x01, `Parity_Err`=1. Sending 0x01 with parity bit 1 gives `Parity_Err`=0.
- Send back-to-back 0x00 then 0xFF with no idle gap -> two `Data_Rdy` pulses exactly 640 clocks apart (10 bits × 64 clocks, parity compiled out), carrying 0x00 and then 0xFF.
- Assert `rst` during DATA bit 4 of a frame, then assert `BIST_Mode` during a second frame -> all outputs at reset values and no strobe for either frame. A subsequent 0x5A frame with `BIST_Mode`=0 is received correctly.
